// File: rtl/irq_pkg.sv
// Shared definitions for the platform interrupt controller: FSM states,
// register word offsets (relative to NUM_SRC) and register bit positions.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_REQ          = 2'd1,
        ST_WAIT_ACK_LOW = 2'd2
    } irq_state_e;

    // Word offsets added to NUM_SRC; words 0..NUM_SRC-1 are per-source config.
    localparam int REG_THRESH_OFS = 0;
    localparam int REG_STATUS_OFS = 1;
    localparam int REG_PEND_OFS   = 2;

    // Width of the claimed-source index reported to the core.
    localparam int ID_W = 4;

    // Bit positions inside the config and status words.
    localparam int CFG_EN_BIT      = 8;
    localparam int STAT_PRIO_LSB   = 8;
    localparam int STAT_UFLOW_BIT  = 16;

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational selector: among the candidate sources, pick the one with the
// highest priority; ties resolve to the lowest index.
module irq_prio_arb
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic [NUM_SRC-1:0]        cand_i,
    input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
    output logic                      valid_o,
    output logic [ID_W-1:0]           idx_o,
    output logic [PRIO_W-1:0]         prio_o
);

    logic                best_valid;
    logic [ID_W-1:0]     best_idx;
    logic [PRIO_W-1:0]   best_prio;

    // Linear scan; strict '>' keeps the earliest (lowest) index on a tie.
    always_comb begin
        best_valid = 1'b0;
        best_idx   = '0;
        best_prio  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand_i[i] && (!best_valid || (prio_i[i*PRIO_W +: PRIO_W] > best_prio))) begin
                best_valid = 1'b1;
                best_idx   = ID_W'(i);
                best_prio  = prio_i[i*PRIO_W +: PRIO_W];
            end
        end
    end

    assign valid_o = best_valid;
    assign idx_o   = best_idx;
    assign prio_o  = best_prio;

endmodule

// File: rtl/irq_controller.sv
// Platform interrupt controller: latches source edges, arbitrates by
// programmable priority, drives irq to the core and keeps a stack of the
// priorities of nested active handlers.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3,
    parameter int NEST_D  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_irq,
    output logic               irq,
    input  logic               irq_ack,
    input  logic               eret_ack,
    output logic [ID_W-1:0]    irq_id,
    input  logic               reg_we,
    input  logic [4:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata
);

    localparam int DEPTH_W = $clog2(NEST_D + 1);
    localparam logic [4:0] ADDR_THRESH = 5'(NUM_SRC + REG_THRESH_OFS);
    localparam logic [4:0] ADDR_STATUS = 5'(NUM_SRC + REG_STATUS_OFS);
    localparam logic [4:0] ADDR_PEND   = 5'(NUM_SRC + REG_PEND_OFS);

    // Source tracking and configuration
    logic [NUM_SRC-1:0]        src_q;
    logic [NUM_SRC-1:0]        pend_q, pend_d;
    logic [NUM_SRC-1:0]        src_rise;
    logic [NUM_SRC-1:0]        en_vec;
    logic [NUM_SRC*PRIO_W-1:0] prio_flat;
    logic [NUM_SRC-1:0]        cand;
    logic [NUM_SRC-1:0]        w1c_mask;
    logic [NUM_SRC-1:0]        claim_mask;
    logic [PRIO_W-1:0]         thresh_q;

    // Active-priority stack
    logic [PRIO_W-1:0]  stk_q [NEST_D];
    logic [PRIO_W-1:0]  stk_d [NEST_D];
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               uflow_q, uflow_d;
    logic [PRIO_W-1:0]  top_prio;
    logic [PRIO_W-1:0]  floor_prio;
    logic               stack_full;

    // Handshake and FSM
    irq_state_e         state_q, state_d;
    logic               irq_q;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic               ack_q, eret_q;
    logic               ack_rise, eret_rise;
    logic               push;

    // Arbiter result
    logic               win_valid;
    logic [ID_W-1:0]    win_idx;
    logic [PRIO_W-1:0]  win_prio;

    // Only a subset of the write data bits is meaningful for any register.
    logic               unused_wdata;
    assign unused_wdata = ^reg_wdata;

    assign src_rise  = src_irq & ~src_q;
    assign ack_rise  = irq_ack & ~ack_q;
    assign eret_rise = eret_ack & ~eret_q;

    assign top_prio   = (depth_q != '0) ? stk_q[0] : '0;
    assign floor_prio = (thresh_q > top_prio) ? thresh_q : top_prio;
    assign stack_full = (depth_q == DEPTH_W'(NEST_D));

    // Per-source configuration word and candidate qualification
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [PRIO_W-1:0] cfg_prio_q;
        logic              cfg_en_q;

        // Priority/enable register for this source
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cfg_prio_q <= '0;
                cfg_en_q   <= 1'b0;
            end else if (reg_we && (reg_addr == 5'(gi))) begin
                cfg_prio_q <= reg_wdata[PRIO_W-1:0];
                cfg_en_q   <= reg_wdata[CFG_EN_BIT];
            end
        end

        assign prio_flat[gi*PRIO_W +: PRIO_W] = cfg_prio_q;
        assign en_vec[gi] = cfg_en_q;
        assign cand[gi]   = pend_q[gi] & cfg_en_q & (cfg_prio_q > floor_prio);
    end

    irq_prio_arb #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_arb (
        .cand_i  (cand),
        .prio_i  (prio_flat),
        .valid_o (win_valid),
        .idx_o   (win_idx),
        .prio_o  (win_prio)
    );

    // Pending bits: a new edge wins over a software clear in the same cycle
    always_comb begin
        w1c_mask   = (reg_we && (reg_addr == ADDR_PEND)) ? reg_wdata[NUM_SRC-1:0] : '0;
        claim_mask = push ? (NUM_SRC'(1) << win_idx) : '0;
        pend_d     = (pend_q & ~w1c_mask & ~claim_mask) | src_rise;
    end

    // Request FSM: raise irq, claim on the ack edge, then wait for ack low
    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        irq_id_d = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid && !stack_full) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!win_valid) begin
                    state_d = ST_IDLE;
                end else if (ack_rise) begin
                    push     = 1'b1;
                    irq_id_d = win_idx;
                    state_d  = ST_WAIT_ACK_LOW;
                end
            end
            ST_WAIT_ACK_LOW: begin
                if (!irq_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stack next state: a return pops first, then a claim pushes
    always_comb begin
        stk_d   = stk_q;
        depth_d = depth_q;
        uflow_d = uflow_q;
        if (eret_rise) begin
            if (depth_q != '0) begin
                for (int i = 0; i < NEST_D - 1; i++) begin
                    stk_d[i] = stk_q[i+1];
                end
                stk_d[NEST_D-1] = '0;
                depth_d = depth_q - DEPTH_W'(1);
            end else begin
                uflow_d = 1'b1;
            end
        end
        if (push) begin
            for (int i = NEST_D - 1; i > 0; i--) begin
                stk_d[i] = stk_d[i-1];
            end
            stk_d[0] = win_prio;
            depth_d  = depth_d + DEPTH_W'(1);
        end
    end

    // State, pending, stack and handshake registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q    <= '0;
            pend_q   <= '0;
            thresh_q <= '0;
            state_q  <= ST_IDLE;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
            ack_q    <= 1'b0;
            eret_q   <= 1'b0;
            stk_q    <= '{default: '0};
            depth_q  <= '0;
            uflow_q  <= 1'b0;
        end else begin
            src_q    <= src_irq;
            pend_q   <= pend_d;
            if (reg_we && (reg_addr == ADDR_THRESH)) begin
                thresh_q <= reg_wdata[PRIO_W-1:0];
            end
            state_q  <= state_d;
            irq_q    <= (state_d == ST_REQ);
            irq_id_q <= irq_id_d;
            ack_q    <= irq_ack;
            eret_q   <= eret_ack;
            stk_q    <= stk_d;
            depth_q  <= depth_d;
            uflow_q  <= uflow_d;
        end
    end

    // Register read mux; unmapped addresses read as zero
    always_comb begin
        reg_rdata = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (reg_addr == 5'(i)) begin
                reg_rdata[PRIO_W-1:0] = prio_flat[i*PRIO_W +: PRIO_W];
                reg_rdata[CFG_EN_BIT] = en_vec[i];
            end
        end
        if (reg_addr == ADDR_THRESH) begin
            reg_rdata[PRIO_W-1:0] = thresh_q;
        end
        if (reg_addr == ADDR_STATUS) begin
            reg_rdata[ID_W-1:0]              = irq_id_q;
            reg_rdata[STAT_PRIO_LSB +: 4]    = 4'(top_prio);
            reg_rdata[STAT_UFLOW_BIT]        = uflow_q;
        end
        if (reg_addr == ADDR_PEND) begin
            reg_rdata[NUM_SRC-1:0] = pend_q;
        end
    end

    assign irq    = irq_q;
    assign irq_id = irq_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: claim, ties, nesting, stack full,
// underflow/threshold, W1C and reset while requesting.
module tb_irq_controller;

    localparam logic [4:0] A_THRESH = 5'd8;
    localparam logic [4:0] A_STATUS = 5'd9;
    localparam logic [4:0] A_PEND   = 5'd10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  src_irq = '0;
    logic        irq;
    logic        irq_ack = 1'b0;
    logic        eret_ack = 1'b0;
    logic [3:0]  irq_id;
    logic        reg_we = 1'b0;
    logic [4:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;

    int total_cnt = 0;
    int pass_cnt  = 0;
    logic [31:0] rv;

    irq_controller #(.NUM_SRC(8), .PRIO_W(3), .NEST_D(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_irq   (src_irq),
        .irq       (irq),
        .irq_ack   (irq_ack),
        .eret_ack  (eret_ack),
        .irq_id    (irq_id),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_we    = 1'b1;
        tick();
        reg_we    = 1'b0;
        reg_wdata = '0;
        $display("wr   addr=%0d data=0x%08h", a, d);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        reg_addr = a;
        #1;
        d = reg_rdata;
    endtask

    task automatic pulse(input logic [7:0] m);
        src_irq = m;
        tick();
        src_irq = '0;
        $display("src  pulse=0x%02h", m);
    endtask

    task automatic ack_claim();
        irq_ack = 1'b1;
        tick();
        $display("ack  rise irq_id=%0d", irq_id);
    endtask

    task automatic ack_release();
        irq_ack = 1'b0;
        tick();
    endtask

    task automatic do_eret();
        eret_ack = 1'b1;
        tick();
        eret_ack = 1'b0;
        tick();
        $display("eret done");
    endtask

    task automatic apply_reset();
        rst = 1'b0; src_irq = '0; irq_ack = 1'b0; eret_ack = 1'b0;
        reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        total_cnt++; if (irq !== 1'b0) $display("FAIL rst_irq: got %0b want 0", irq); else pass_cnt++;
        total_cnt++; if (irq_id !== 4'd0) $display("FAIL rst_id: got %0d want 0", irq_id); else pass_cnt++;
        rd(A_STATUS, rv);
        total_cnt++; if (rv !== 32'h0) $display("FAIL rst_status: got 0x%h want 0x0", rv); else pass_cnt++;
        rd(A_PEND, rv);
        total_cnt++; if (rv !== 32'h0) $display("FAIL rst_pend: got 0x%h want 0x0", rv); else pass_cnt++;
    endtask

    task automatic test_basic();
        apply_reset();
        wr(5'd2, 32'h103);
        rd(5'd2, rv);
        total_cnt++; if (rv !== 32'h103) $display("FAIL t1_cfg: got 0x%h want 0x103", rv); else pass_cnt++;
        pulse(8'h04);
        rd(A_PEND, rv);
        total_cnt++; if (rv !== 32'h04) $display("FAIL t1_pend: got 0x%h want 0x04", rv); else pass_cnt++;
        tick();
        total_cnt++; if (irq !== 1'b1) $display("FAIL t1_irq_up: got %0b want 1", irq); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (irq !== 1'b1) $display("FAIL t1_irq_hold: got %0b want 1", irq); else pass_cnt++;
        ack_claim();
        total_cnt++; if (irq !== 1'b0) $display("FAIL t1_irq_drop: got %0b want 0", irq); else pass_cnt++;
        total_cnt++; if (irq_id !== 4'd2) $display("FAIL t1_id: got %0d want 2", irq_id); else pass_cnt++;
        rd(A_PEND, rv);
        total_cnt++; if (rv !== 32'h0) $display("FAIL t1_pend_clr: got 0x%h want 0x0", rv); else pass_cnt++;
        rd(A_STATUS, rv);
        total_cnt++; if (rv !== 32'h302) $display("FAIL t1_status: got 0x%h want 0x302", rv); else pass_cnt++;
        tick();
        total_cnt++; if (irq !== 1'b0) $display("FAIL t1_irq_ackhold: got %0b want 0", irq); else pass_cnt++;
        ack_release();
        do_eret();
        rd(A_STATUS, rv);
        total_cnt++; if (rv !== 32'h002) $display("FAIL t1_status_ret: got 0x%h want 0x002", rv); else pass_cnt++;
    endtask

    task automatic test_tie();
        apply_reset();
        wr(5'd1, 32'h104);
        wr(5'd5, 32'h104);
        pulse(8'h22);
        tick();
        total_cnt++; if (irq !== 1'b1) $display("FAIL t2_irq: got %0b want 1", irq); else pass_cnt++;
        ack_claim();
        total_cnt++; if (irq_id !== 4'd1) $display("FAIL t2_id_first: got %0d want 1", irq_id); else pass_cnt++;
        ack_release();
        tick(); tick();
        total_cnt++; if (irq !== 1'b0) $display("FAIL t2_blocked: got %0b want 0", irq); else pass_cnt++;
        rd(A_PEND, rv);
        total_cnt++; if (rv !== 32'h20) $display("FAIL t2_pend5: got 0x%h want 0x20", rv); else pass_cnt++;
        do_eret();
        total_cnt++; if (irq !== 1'b1) $display("FAIL t2_irq_after_eret: got %0b want 1", irq); else pass_cnt++;
        ack_claim();
        total_cnt++; if (irq_id !== 4'd5) $display("FAIL t2_id_second: got %0d want 5", irq_id); else pass_cnt++;
        ack_release();
        do_eret();
    endtask

    task automatic test_nesting();
        apply_reset();
        wr(5'd0, 32'h102);
        wr(5'd3, 32'h106);
        wr(5'd4, 32'h102);
        pulse(8'h01);
        tick();
        ack_claim();
        total_cnt++; if (irq_id !== 4'd0) $display("FAIL t3_id_outer: got %0d want 0", irq_id); else pass_cnt++;
        ack_release();
        pulse(8'h08);
        tick();
        total_cnt++; if (irq !== 1'b1) $display("FAIL t3_nest_irq: got %0b want 1", irq); else pass_cnt++;
        ack_claim();
        total_cnt++; if (irq_id !== 4'd3) $display("FAIL t3_id_inner: got %0d want 3", irq_id); else pass_cnt++;
        rd(A_STATUS, rv);
        total_cnt++; if (rv !== 32'h603) $display("FAIL t3_status: got 0x%h want 0x603", rv); else pass_cnt++;
        ack_release();
        pulse(8'h10);
        tick();
        total_cnt++; if (irq !== 1'b0) $display("FAIL t3_low_blocked0: got %0b want 0", irq); else pass_cnt++;
        do_eret();
        total_cnt++; if (irq !== 1'b0) $display("FAIL t3_low_blocked1: got %0b want 0", irq); else pass_cnt++;
        do_eret();
        total_cnt++; if (irq !== 1'b1) $display("FAIL t3_low_req: got %0b want 1", irq); else pass_cnt++;
        ack_claim();
        total_cnt++; if (irq_id !== 4'd4) $display("FAIL t3_id_low: got %0d want 4", irq_id); else pass_cnt++;
        ack_release();
    endtask

    task automatic test_stack_full();
        logic [7:0] m;
        apply_reset();
        for (int i = 0; i < 4; i++) wr(5'(i), 32'h100 | (i + 1));
        wr(5'd7, 32'h107);
        for (int i = 0; i < 4; i++) begin
            m = 8'h01 << i;
            pulse(m);
            tick();
            ack_claim();
            total_cnt++; if (irq_id !== 4'(i)) $display("FAIL t4_fill_id: got %0d want %0d", irq_id, i); else pass_cnt++;
            ack_release();
        end
        rd(A_STATUS, rv);
        total_cnt++; if (rv !== 32'h403) $display("FAIL t4_status_full: got 0x%h want 0x403", rv); else pass_cnt++;
        pulse(8'h80);
        tick(); tick();
        total_cnt++; if (irq !== 1'b0) $display("FAIL t4_full_blocks: got %0b want 0", irq); else pass_cnt++;
        rd(A_PEND, rv);
        total_cnt++; if (rv !== 32'h80) $display("FAIL t4_pend_kept: got 0x%h want 0x80", rv); else pass_cnt++;
        do_eret();
        total_cnt++; if (irq !== 1'b1) $display("FAIL t4_req_after_pop: got %0b want 1", irq); else pass_cnt++;
        ack_claim();
        total_cnt++; if (irq_id !== 4'd7) $display("FAIL t4_id7: got %0d want 7", irq_id); else pass_cnt++;
        ack_release();
    endtask

    task automatic test_underflow_thresh();
        apply_reset();
        do_eret();
        total_cnt++; if (irq !== 1'b0) $display("FAIL t5_uf_irq: got %0b want 0", irq); else pass_cnt++;
        rd(A_STATUS, rv);
        total_cnt++; if (rv !== 32'h10000) $display("FAIL t5_uf_status: got 0x%h want 0x10000", rv); else pass_cnt++;
        wr(A_THRESH, 32'h5);
        rd(A_THRESH, rv);
        total_cnt++; if (rv !== 32'h5) $display("FAIL t5_thresh_rd: got 0x%h want 0x5", rv); else pass_cnt++;
        wr(5'd1, 32'h105);
        wr(5'd2, 32'h106);
        pulse(8'h02);
        tick(); tick();
        total_cnt++; if (irq !== 1'b0) $display("FAIL t5_thresh_blocks: got %0b want 0", irq); else pass_cnt++;
        pulse(8'h04);
        tick();
        total_cnt++; if (irq !== 1'b1) $display("FAIL t5_above_thresh: got %0b want 1", irq); else pass_cnt++;
        ack_claim();
        total_cnt++; if (irq_id !== 4'd2) $display("FAIL t5_id: got %0d want 2", irq_id); else pass_cnt++;
        rd(A_STATUS, rv);
        total_cnt++; if (rv !== 32'h10602) $display("FAIL t5_status: got 0x%h want 0x10602", rv); else pass_cnt++;
        ack_release();
    endtask

    task automatic test_w1c();
        apply_reset();
        wr(5'd6, 32'h103);
        pulse(8'h40);
        tick();
        total_cnt++; if (irq !== 1'b1) $display("FAIL w1c_irq_up: got %0b want 1", irq); else pass_cnt++;
        wr(A_PEND, 32'h40);
        tick();
        total_cnt++; if (irq !== 1'b0) $display("FAIL w1c_irq_drop: got %0b want 0", irq); else pass_cnt++;
        rd(A_PEND, rv);
        total_cnt++; if (rv !== 32'h0) $display("FAIL w1c_pend: got 0x%h want 0x0", rv); else pass_cnt++;
        src_irq = 8'h01;
        wr(A_PEND, 32'h01);
        src_irq = 8'h00;
        rd(A_PEND, rv);
        total_cnt++; if (rv !== 32'h01) $display("FAIL w1c_set_wins: got 0x%h want 0x01", rv); else pass_cnt++;
        rd(5'd20, rv);
        total_cnt++; if (rv !== 32'h0) $display("FAIL unmapped_rd: got 0x%h want 0x0", rv); else pass_cnt++;
    endtask

    task automatic test_reset_in_req();
        apply_reset();
        wr(5'd0, 32'h101);
        wr(5'd1, 32'h102);
        wr(5'd2, 32'h103);
        pulse(8'h01); tick(); ack_claim(); ack_release();
        pulse(8'h02); tick(); ack_claim(); ack_release();
        pulse(8'h04);
        tick();
        total_cnt++; if (irq !== 1'b1) $display("FAIL t6_in_req: got %0b want 1", irq); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (irq !== 1'b0) $display("FAIL t6_rst_irq: got %0b want 0", irq); else pass_cnt++;
        rd(A_STATUS, rv);
        total_cnt++; if (rv !== 32'h0) $display("FAIL t6_rst_status: got 0x%h want 0x0", rv); else pass_cnt++;
        rd(5'd0, rv);
        total_cnt++; if (rv !== 32'h0) $display("FAIL t6_rst_cfg: got 0x%h want 0x0", rv); else pass_cnt++;
        tick();
        rst = 1'b1;
        tick();
        pulse(8'h04);
        tick(); tick();
        total_cnt++; if (irq !== 1'b0) $display("FAIL t6_stays_low: got %0b want 0", irq); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_nesting();
        test_stack_full();
        test_underflow_thresh();
        test_w1c();
        test_reset_in_req();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
